ysyx_pipe_buf: RTL
==================

# ysyx_pipe_buf

Parametrised elastic pipeline buffer that replaces the fixed single-register hand-off between front-end stages, such as IDU→EXU and EXU→commit. It carries an opaque packed payload of `WIDTH` bits in up to `DEPTH` entries, using a valid/ready handshake on both sides. It supports a whole-buffer flush for mispredict and trap redirects, and exposes occupancy to the issue logic.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits; must be ≥1.
- `DEPTH`, 2: number of entries; power of two, ≥1. `DEPTH=1` gives a plain registered stage.

Ports:
- `clock`, in, 1: the single clock; all state updates on its rising edge.
- `reset_n`, in, 1: reset, asynchronous assert, active-low.
- `flush`, in, 1: synchronous squash of every held entry.
- `in_valid`, in, 1: upstream payload valid.
- `in_ready`, out, 1: buffer accepts this cycle.
- `in_data`, in, `WIDTH`: upstream payload.
- `out_valid`, out, 1: head payload valid.
- `out_ready`, in, 1: downstream consumes this cycle.
- `out_data`, out, `WIDTH`: head payload.
- `count`, out, `$clog2(DEPTH+1)`: entries held.
- `full`, out, 1: `count == DEPTH`.
- `empty`, out, 1: `count == 0`.

## Operation
- Storage is a circular array of `DEPTH` entries with read pointer `rp`, write pointer `wp` and counter `cnt`. Pointers are `max(1,$clog2(DEPTH))` bits and wrap modulo `DEPTH`.
- Push = `in_valid && in_ready`. Pop = `out_valid && out_ready`.
- `in_ready = reset_n && !flush && !full`. There is no combinational path from `out_ready` to `in_ready`. When full, a push is refused even if a pop happens in the same cycle.
- `out_valid = !flush && !empty` (extended under Configuration). `out_data = mem[rp]`. When empty, `out_data` is don't-care.
- On push: `mem[wp] <= in_data`, `wp <= wp+1`.
- On pop: `rp <= rp+1`.
- `cnt` changes by `+push −pop`. A simultaneous push and pop leaves `cnt` unchanged.
- Flush has priority over everything. On the next edge `rp = wp = cnt = 0`. No push or pop is taken in the flush cycle. Memory contents are not cleared.
- Payload is never modified, reordered or duplicated. Output order is strictly FIFO.

## Timing
- Reset (`reset_n` low, asynchronous): `rp`, `wp` and `cnt` are 0. Outputs are `out_valid=0`, `in_ready=0`, `empty=1`, `full=0`, `count=0`.
- First edge after `reset_n` rises: `in_ready=1`.
- If reset is asserted mid-operation, all held entries are lost immediately. No partial handshake completes in that cycle.
- Latency (bypass off): a payload pushed at edge N is visible on `out_data` with `out_valid=1` from edge N onward, i.e. 1 cycle.
- Throughput: 1 payload per cycle sustained when `DEPTH≥2` and `out_ready` is held high.
  - With `DEPTH=1`, throughput is 1 payload per 2 cycles, because a full buffer refuses a push even while popping.
- A payload may only be dropped by flush or reset. Once `out_valid` is high, `out_data` stays stable until pop or flush.
- Boundaries:
  - Pushing when `cnt = DEPTH−1` sets `full` on the next cycle.
  - Popping the last entry sets `empty` on the next cycle.
  - `wp` and `rp` wrap from `DEPTH−1` to 0 with no bubble.
- Flush asserted together with `in_valid`: `in_ready=0`, so the upstream must hold or drop its payload. The buffer records nothing.

## Configuration
- `YSYX_PIPE_BUF_BYPASS_EN` defined: when `empty && in_valid && !flush`, the buffer drives `out_valid=1` and `out_data=in_data` combinationally in the same cycle.
  - If `out_ready` is also high, the payload passes through with 0 latency. No write occurs and `cnt` stays 0.
  - Otherwise the payload is stored normally.
  - `in_ready` is unchanged.
- Undefined: no bypass. Minimum latency is 1 cycle and there is no combinational in→out path.

## Test plan
- Reset then fill: hold `reset_n` low for 3 cycles, release, push 0x11, 0x22 with `out_ready=0` at `DEPTH=2` → `full=1`, `count=2`, `in_ready=0`, `out_data=0x11`.
- Streaming: push 0x1..0x8 back to back with `out_ready=1`, `DEPTH=4` → outputs appear in order 0x1..0x8, 1 per cycle after a 1-cycle delay, and `count` never exceeds 1.
- Wrap and backpressure: at `DEPTH=4`, apply random `out_ready` (50%) over 100 pushes of incrementing data → output sequence equals the input sequence, and `wp`/`rp` wrap at least 20 times with no loss.
- Flush: at `DEPTH=4` holding 3 entries, assert `flush` together with `in_valid` (data 0xAA) → next cycle `count=0` and `empty=1`; 0xAA is never output; the first push afterwards is output as the head.
- Async reset mid-stream: at `count=2`, drop `reset_n` between edges → `out_valid=0` and `count=0` immediately, without waiting for a clock edge.
- Bypass (macro defined): with the buffer empty, `in_valid=1`, `in_data=0x5A`, `out_ready=1` → the same cycle shows `out_valid=1`, `out_data=0x5A`, and `count` stays 0. Without the macro, `out_valid` rises one cycle later.

Source files
------------

// File: rtl/ysyx_pipe_buf.sv
// Elastic valid/ready pipeline buffer: circular FIFO of DEPTH x WIDTH entries with flush.
// Define YSYX_PIPE_BUF_BYPASS_EN to let an empty buffer forward in_data combinationally.
module ysyx_pipe_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    // DEPTH=1 still needs a 1-bit pointer; the pointer is pinned at 0 so entry 1 is never used.
    localparam int unsigned NENT = 1 << AW;

    logic [WIDTH-1:0] mem [NENT];
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic bypass;
    logic pass;
    logic push;
    logic pop;
    logic wr_en;
    logic rd_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (DEPTH == 1) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

`ifdef YSYX_PIPE_BUF_BYPASS_EN
    assign bypass = reset_n && empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        full      = (cnt_q == CW'(DEPTH));
        empty     = (cnt_q == '0);
        count     = cnt_q;
        in_ready  = reset_n && !flush && !full;
        out_valid = (!flush && !empty) || bypass;
        out_data  = bypass ? in_data : mem[rp_q];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        // A bypassed payload consumed in the same cycle never touches storage.
        pass      = bypass && out_ready;
        wr_en     = push && !pass;
        rd_en     = pop && !pass;
    end

    always_comb begin
        rp_d  = rp_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (flush) begin
            rp_d  = '0;
            wp_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr_en) begin
                wp_d = ptr_inc(wp_q);
            end
            if (rd_en) begin
                rp_d = ptr_inc(rp_q);
            end
            if (wr_en && !rd_en) begin
                cnt_d = cnt_q + CW'(1);
            end else if (rd_en && !wr_en) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rp_q  <= '0;
            wp_q  <= '0;
            cnt_q <= '0;
        end else begin
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage carries no reset; a flush only rewinds the pointers.
    always_ff @(posedge clock) begin
        if (wr_en && !flush) begin
            mem[wp_q] <= in_data;
        end
    end

endmodule
